// File: rtl/riscv_mem_arbiter.sv
// Two-into-one val/rdy memory request arbiter for the core's imem and dmem ports.
// An in-order tag FIFO steers each memory response back to the port that issued it.
module riscv_mem_arbiter #(
    parameter int unsigned REQ_SZ    = 67,
    parameter int unsigned RESP_SZ   = 35,
    parameter int unsigned MAX_OUT   = 4,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [REQ_SZ-1:0]            imemreq_msg,
    input  logic                         imemreq_val,
    output logic                         imemreq_rdy,
    output logic [RESP_SZ-1:0]           imemresp_msg,
    output logic                         imemresp_val,

    input  logic [REQ_SZ-1:0]            dmemreq_msg,
    input  logic                         dmemreq_val,
    output logic                         dmemreq_rdy,
    output logic [RESP_SZ-1:0]           dmemresp_msg,
    output logic                         dmemresp_val,

    output logic [REQ_SZ-1:0]            memreq_msg,
    output logic                         memreq_val,
    input  logic                         memreq_rdy,
    input  logic [RESP_SZ-1:0]           memresp_msg,
    input  logic                         memresp_val,

    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         resp_err
);

    localparam int unsigned PtrW = $clog2(MAX_OUT);
    localparam int unsigned CntW = PtrW + 1;

    logic [MAX_OUT-1:0] tags_q;
    logic [PtrW-1:0]    head_q, tail_q;
    logic [CntW-1:0]    count_q;
    logic               last_grant_q;
    logic               resp_err_q;

    logic full, empty, grant, fire, pop, head_tag;

    // Full blocks issue even if a response pops this cycle: no memresp -> memreq path.
    assign full     = (count_q == CntW'(MAX_OUT));
    assign empty    = (count_q == '0);
    assign head_tag = tags_q[head_q];

    always_comb begin
        grant = dmemreq_val;
        if (imemreq_val && dmemreq_val) begin
            grant = (FIXED_PRI != 0) ? 1'b1 : ~last_grant_q;
        end
    end

    assign memreq_val  = (imemreq_val | dmemreq_val) & ~full;
    assign memreq_msg  = grant ? dmemreq_msg : imemreq_msg;
    assign imemreq_rdy = imemreq_val & ~grant & memreq_rdy & ~full;
    assign dmemreq_rdy = dmemreq_val &  grant & memreq_rdy & ~full;

    assign fire = memreq_val & memreq_rdy;
    assign pop  = memresp_val & ~empty;

    assign imemresp_val = pop & ~head_tag;
    assign dmemresp_val = pop &  head_tag;
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;

    assign outstanding = count_q;
    assign resp_err    = resp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tags_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            resp_err_q   <= 1'b0;
        end else begin
            if (fire) begin
                tags_q[tail_q] <= grant;
                tail_q         <= tail_q + 1'b1;
                last_grant_q   <= grant;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            if (fire && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!fire && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (memresp_val && empty) begin
                resp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are compared against a queue-based reference model, plus table and directed sequences.
module tb_riscv_mem_arbiter;

    localparam int unsigned REQ_SZ  = 67;
    localparam int unsigned RESP_SZ = 35;
    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset;
    logic [REQ_SZ-1:0]  imsg, dmsg;
    logic               iv, dv, mrdy, rv;
    logic [RESP_SZ-1:0] rmsg;

    logic               irdy[2], drdy[2], ival[2], dval[2], mval[2], err_o[2];
    logic [RESP_SZ-1:0] irmsg[2], drmsg[2];
    logic [REQ_SZ-1:0]  mmsg[2];
    logic [2:0]         outs[2];

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .MAX_OUT(MAX_OUT), .FIXED_PRI(0))
    u_rr (
        .clk(clk), .reset(reset),
        .imemreq_msg(imsg), .imemreq_val(iv), .imemreq_rdy(irdy[0]),
        .imemresp_msg(irmsg[0]), .imemresp_val(ival[0]),
        .dmemreq_msg(dmsg), .dmemreq_val(dv), .dmemreq_rdy(drdy[0]),
        .dmemresp_msg(drmsg[0]), .dmemresp_val(dval[0]),
        .memreq_msg(mmsg[0]), .memreq_val(mval[0]), .memreq_rdy(mrdy),
        .memresp_msg(rmsg), .memresp_val(rv),
        .outstanding(outs[0]), .resp_err(err_o[0])
    );

    riscv_mem_arbiter #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .MAX_OUT(MAX_OUT), .FIXED_PRI(1))
    u_fx (
        .clk(clk), .reset(reset),
        .imemreq_msg(imsg), .imemreq_val(iv), .imemreq_rdy(irdy[1]),
        .imemresp_msg(irmsg[1]), .imemresp_val(ival[1]),
        .dmemreq_msg(dmsg), .dmemreq_val(dv), .dmemreq_rdy(drdy[1]),
        .dmemresp_msg(drmsg[1]), .dmemresp_val(dval[1]),
        .memreq_msg(mmsg[1]), .memreq_val(mval[1]), .memreq_rdy(mrdy),
        .memresp_msg(rmsg), .memresp_val(rv),
        .outstanding(outs[1]), .resp_err(err_o[1])
    );

    // Reference model: queue of issuing ports per instance, last grant, sticky error.
    bit q0[$];
    bit q1[$];
    bit lg[2];
    bit merr[2];
    bit g_s[2], fire_s[2], pop_s[2], stray_s[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_msgs();
        imsg = REQ_SZ'({$urandom(), $urandom(), $urandom()});
        dmsg = REQ_SZ'({$urandom(), $urandom(), $urandom()});
        rmsg = RESP_SZ'({$urandom(), $urandom()});
    endtask

    task automatic set_in(input bit i, input bit d, input bit r, input bit resp);
        iv = i; dv = d; mrdy = r; rv = resp;
        rand_msgs();
    endtask

    // Evaluate combinational outputs of both instances against the model.
    task automatic settle();
        #2;
        for (int m = 0; m < 2; m++) begin
            int    sz;
            bit    front, full, g, e_mval;
            string pre;
            pre   = (m == 0) ? "rr" : "fx";
            sz    = (m == 0) ? q0.size() : q1.size();
            front = 1'b0;
            if (sz > 0) front = (m == 0) ? q0[0] : q1[0];
            full  = (sz == MAX_OUT);
            g     = (iv && dv) ? ((m == 1) ? 1'b1 : !lg[m]) : dv;
            e_mval = (iv || dv) && !full;
            chk({pre, " memreq_val"}, 128'(mval[m]), 128'(e_mval));
            if (e_mval) chk({pre, " memreq_msg"}, 128'(mmsg[m]), 128'(g ? dmsg : imsg));
            chk({pre, " imemreq_rdy"}, 128'(irdy[m]), 128'(iv && !g && mrdy && !full));
            chk({pre, " dmemreq_rdy"}, 128'(drdy[m]), 128'(dv && g && mrdy && !full));
            chk({pre, " imemresp_val"}, 128'(ival[m]), 128'(rv && sz > 0 && !front));
            chk({pre, " dmemresp_val"}, 128'(dval[m]), 128'(rv && sz > 0 && front));
            chk({pre, " imemresp_msg"}, 128'(irmsg[m]), 128'(rmsg));
            chk({pre, " dmemresp_msg"}, 128'(drmsg[m]), 128'(rmsg));
            chk({pre, " outstanding"}, 128'(outs[m]), 128'(sz));
            chk({pre, " resp_err"}, 128'(err_o[m]), 128'(merr[m]));
            g_s[m]     = g;
            fire_s[m]  = e_mval && mrdy;
            pop_s[m]   = rv && sz > 0;
            stray_s[m] = rv && sz == 0;
        end
    endtask

    task automatic tick();
        for (int m = 0; m < 2; m++) begin
            if (pop_s[m]) begin
                if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (fire_s[m]) begin
                if (m == 0) q0.push_back(g_s[m]); else q1.push_back(g_s[m]);
                lg[m] = g_s[m];
            end
            if (stray_s[m]) merr[m] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        lg   = '{1'b1, 1'b1};
        merr = '{1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            set_in(1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
            #2;
            for (int m = 0; m < 2; m++) begin
                chk("reset outstanding", 128'(outs[m]), 128'(0));
                chk("reset resp_err", 128'(err_o[m]), 128'(0));
            end
            @(posedge clk);
            #1;
        end
        set_in(0, 0, 0, 0);
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q0.size() > 0; k++) begin
            set_in(0, 0, 1, 1);
            cycle();
        end
        chk("drain outstanding", 128'(outs[0]), 128'(0));
    endtask

    typedef struct {
        bit iv, dv, mrdy, rv;
        bit e_irdy, e_drdy, e_mval, e_iresp, e_dresp;
        int e_out;
    } vec_t;

    vec_t vt[6];

    initial begin
        // Round-robin conflict with one-cycle memory answers (rr instance expectations).
        vt[0] = '{1, 1, 1, 0,  1, 0, 1, 0, 0,  0};
        vt[1] = '{1, 1, 1, 1,  0, 1, 1, 1, 0,  1};
        vt[2] = '{1, 1, 1, 1,  1, 0, 1, 0, 1,  1};
        vt[3] = '{1, 1, 1, 1,  0, 1, 1, 1, 0,  1};
        vt[4] = '{0, 0, 0, 1,  0, 0, 0, 0, 1,  1};
        vt[5] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0};

        set_in(0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset / idle
        do_reset();
        settle();
        for (int m = 0; m < 2; m++) begin
            chk("idle vals/rdys", 128'({mval[m], irdy[m], drdy[m], ival[m], dval[m]}), 128'(0));
        end
        tick();

        // Table-driven round-robin sequence
        for (int i = 0; i < 6; i++) begin
            set_in(vt[i].iv, vt[i].dv, vt[i].mrdy, vt[i].rv);
            settle();
            chk($sformatf("vec%0d imemreq_rdy", i), 128'(irdy[0]), 128'(vt[i].e_irdy));
            chk($sformatf("vec%0d dmemreq_rdy", i), 128'(drdy[0]), 128'(vt[i].e_drdy));
            chk($sformatf("vec%0d memreq_val", i), 128'(mval[0]), 128'(vt[i].e_mval));
            chk($sformatf("vec%0d imemresp_val", i), 128'(ival[0]), 128'(vt[i].e_iresp));
            chk($sformatf("vec%0d dmemresp_val", i), 128'(dval[0]), 128'(vt[i].e_dresp));
            chk($sformatf("vec%0d outstanding", i), 128'(outs[0]), 128'(vt[i].e_out));
            tick();
        end

        // Fixed priority: dmem wins every conflict
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 1, 0);
            settle();
            chk("fixed imemreq_rdy", 128'(irdy[1]), 128'(0));
            chk("fixed dmemreq_rdy", 128'(drdy[1]), 128'(1));
            tick();
        end
        drain();

        // Full backpressure
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 1, 0);
            cycle();
        end
        set_in(1, 0, 1, 1);
        settle();
        chk("full outstanding", 128'(outs[0]), 128'(4));
        chk("full memreq_val", 128'(mval[0]), 128'(0));
        chk("full imemreq_rdy", 128'(irdy[0]), 128'(0));
        chk("full pop imemresp_val", 128'(ival[0]), 128'(1));
        tick();
        set_in(1, 0, 1, 0);
        settle();
        chk("resume outstanding", 128'(outs[0]), 128'(3));
        chk("resume memreq_val", 128'(mval[0]), 128'(1));
        tick();
        drain();

        // Wrap-around with simultaneous push/pop
        for (int k = 0; k < 10; k++) begin
            set_in(k[0] == 1'b0, k[0] == 1'b1, 1, (k > 0) && (k % 3 != 2));
            cycle();
        end
        drain();

        // Stray response
        set_in(0, 0, 0, 1);
        settle();
        chk("stray imemresp_val", 128'(ival[0]), 128'(0));
        chk("stray dmemresp_val", 128'(dval[0]), 128'(0));
        tick();
        set_in(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("stray resp_err sticky", 128'(err_o[0]), 128'(1));
            tick();
        end
        do_reset();
        settle();
        chk("resp_err cleared", 128'(err_o[0]), 128'(0));
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit r;
            r = (q0.size() > 0) ? 1'($urandom()) : ($urandom_range(0, 49) == 0);
            set_in(1'($urandom()), 1'($urandom()), ($urandom_range(0, 3) != 0), r);
            cycle();
            if (k == 200) do_reset();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
